// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory burst arbiter: FSM state
// encoding, owner tag and the default cache-line length.
package cache_mem_arbiter_pkg;

   localparam int unsigned LINE_WORDS_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IC_BURST = 2'd1,
      ST_DC_BURST = 2'd2,
      ST_DONE     = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_e;

   // Clears the byte/word offset bits so the line base can be OR-ed with the beat offset.
   function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned off_bits);
      return addr & ~((32'd1 << off_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache line bursts onto a single memory port, with
// round-robin tie-breaking and a one-cycle DONE gap between bursts.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
   localparam int unsigned IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ic_req,
   input  logic [31:0]      ic_addr,
   output logic             ic_gnt,
   output logic             ic_valid,
   output logic             ic_last,
   input  logic             dc_req,
   input  logic             dc_we,
   input  logic [31:0]      dc_addr,
   input  logic [31:0]      dc_din,
   output logic             dc_gnt,
   output logic             dc_valid,
   output logic             dc_last,
   output logic [IDX_W-1:0] word_idx,
   output logic [31:0]      rd_data,
   output logic             mem_cs,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_dout,
   input  logic [31:0]      mem_din,
   input  logic             mem_ack
);

   localparam int unsigned      OFF_W    = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   arb_state_e       state_q,       state_d;
   logic [IDX_W-1:0] word_idx_q,    word_idx_d;
   logic [31:0]      line_addr_q,   line_addr_d;
   logic             we_q,          we_d;
   owner_e           owner_q,       owner_d;
   owner_e           last_served_q, last_served_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         word_idx_q    <= '0;
         line_addr_q   <= '0;
         we_q          <= 1'b0;
         owner_q       <= OWN_IC;
         last_served_q <= OWN_IC;
      end else begin
         state_q       <= state_d;
         word_idx_q    <= word_idx_d;
         line_addr_q   <= line_addr_d;
         we_q          <= we_d;
         owner_q       <= owner_d;
         last_served_q <= last_served_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      word_idx_d    = word_idx_q;
      line_addr_d   = line_addr_q;
      we_d          = we_q;
      owner_d       = owner_q;
      last_served_d = last_served_q;
      ic_gnt        = 1'b0;
      ic_valid      = 1'b0;
      ic_last       = 1'b0;
      dc_gnt        = 1'b0;
      dc_valid      = 1'b0;
      dc_last       = 1'b0;
      mem_cs        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (ic_req || dc_req) begin
               word_idx_d = '0;
               // On a tie the dcache wins only if the icache was served last.
               if (dc_req && (!ic_req || last_served_q == OWN_IC)) begin
                  state_d     = ST_DC_BURST;
                  owner_d     = OWN_DC;
                  line_addr_d = line_base(dc_addr, OFF_W);
                  we_d        = dc_we;
               end else begin
                  state_d     = ST_IC_BURST;
                  owner_d     = OWN_IC;
                  line_addr_d = line_base(ic_addr, OFF_W);
                  we_d        = 1'b0;
               end
            end
         end
         ST_IC_BURST: begin
            ic_gnt   = 1'b1;
            mem_cs   = 1'b1;
            mem_addr = line_addr_q | {{(32-OFF_W){1'b0}}, word_idx_q, 2'b00};
            if (mem_ack) begin
               ic_valid   = 1'b1;
               ic_last    = (word_idx_q == LAST_IDX);
               word_idx_d = word_idx_q + 1'b1;
               if (word_idx_q == LAST_IDX) state_d = ST_DONE;
            end
         end
         ST_DC_BURST: begin
            dc_gnt   = 1'b1;
            mem_cs   = 1'b1;
            mem_we   = we_q;
            mem_addr = line_addr_q | {{(32-OFF_W){1'b0}}, word_idx_q, 2'b00};
            if (mem_ack) begin
               dc_valid   = !we_q;
               dc_last    = (word_idx_q == LAST_IDX);
               word_idx_d = word_idx_q + 1'b1;
               if (word_idx_q == LAST_IDX) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            last_served_d = owner_q;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign word_idx = word_idx_q;
   assign rd_data  = mem_din;
   assign mem_dout = dc_din;

endmodule
